fft_32_frame_scheduler: RTL and testbench

Shares one fft_32 instance between NUM_CHANNELS sample requesters. The block:
- grants whole 32-sample frames round-robin;
- generates Input_index and Input_last for the FFT;
- enforces a minimum idle gap between frames so the FFT never raises Error_input_overflow;
- tags each FFT output frame with its source channel through a small tag FIFO.

It sits between the channel front-ends and fft_32 (input and output sides).

---
 rtl/fft_32_frame_scheduler.sv | 137 +++++++++++++
 tb/tb_fft_32_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_32_frame_scheduler.sv
// fft_32_frame_scheduler: shares one fft_32 between NUM_CHANNELS requesters, one whole 32-sample frame at a time.
// Ports: Clk, Rst (sync, active high); Chan_valid/Chan_i/Chan_q/Chan_ready per-channel sample handshake;
// Fft_valid/Fft_i/Fft_q/Fft_index/Fft_last drive the fft_32 input; Fft_out_valid/Fft_out_last pop the tag FIFO;
// Out_channel names the source of the emerging output frame; Error_tag_overflow/Error_tag_underflow one-cycle pulses.
// Define FFT_SCHED_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module fft_32_frame_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MIN_FRAME_GAP = 32,
  parameter int TAG_FIFO_DEPTH = 4,
  localparam int CW = $clog2(NUM_CHANNELS),
  localparam int AW = $clog2(TAG_FIFO_DEPTH)
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [NUM_CHANNELS-1:0]            Chan_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Chan_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Chan_q,
  output logic [NUM_CHANNELS-1:0]            Chan_ready,
  output logic                               Fft_valid,
  output logic [DATA_WIDTH-1:0]              Fft_i,
  output logic [DATA_WIDTH-1:0]              Fft_q,
  output logic [4:0]                         Fft_index,
  output logic                               Fft_last,
  input  logic                               Fft_out_valid,
  input  logic                               Fft_out_last,
  output logic [CW-1:0]                      Out_channel,
  output logic                               Error_tag_overflow,
  output logic                               Error_tag_underflow
);
  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] grant, pick, idx;
  logic [4:0] count;
  logic [7:0] gap_cnt;
  logic [CW-1:0] tag_mem [TAG_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0] occ;
  logic [DATA_WIDTH-1:0] sel_i, sel_q;
  logic full, empty, push, pop, do_push, do_pop, accept;
`ifndef FFT_SCHED_FIXED_PRIORITY_EN
  logic [CW-1:0] rr_ptr;
`endif
  assign full = occ == (AW+1)'(TAG_FIFO_DEPTH);
  assign empty = occ == '0;
  assign accept = state == S_FRAME && Chan_valid[grant] && Chan_ready[grant];
  assign pop = Fft_out_valid && Fft_out_last;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_ptr_n = rd_ptr + AW'(do_pop);
  always_comb begin
    pick = '0;
    idx = '0;
    sel_i = '0;
    sel_q = '0;
`ifdef FFT_SCHED_FIXED_PRIORITY_EN
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      idx = CW'(k);
      if (Chan_valid[idx]) pick = idx;
    end
`else
    // Scan downward so the nearest requester after the pointer is the last to win.
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      idx = CW'((int'(rr_ptr) + k) % NUM_CHANNELS);
      if (Chan_valid[idx]) pick = idx;
    end
`endif
    for (int n = 0; n < NUM_CHANNELS; n++)
      if (grant == CW'(n)) begin
        sel_i = Chan_i[n*DATA_WIDTH +: DATA_WIDTH];
        sel_q = Chan_q[n*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  always_comb begin
    state_n = state;
    push = 1'b0;
    if (state == S_IDLE && |Chan_valid && !full) begin
      state_n = S_FRAME;
      push = 1'b1;
    end else if (accept && count == 5'd31) state_n = S_GAP;
    else if (state == S_GAP && gap_cnt == 8'd1) state_n = S_IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      grant <= '0;
`ifndef FFT_SCHED_FIXED_PRIORITY_EN
      rr_ptr <= CW'(NUM_CHANNELS - 1);
`endif
      count <= '0;
      gap_cnt <= '0;
      Chan_ready <= '0;
      Fft_valid <= 1'b0;
      Fft_i <= '0;
      Fft_q <= '0;
      Fft_index <= '0;
      Fft_last <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      Out_channel <= '0;
      Error_tag_overflow <= 1'b0;
      Error_tag_underflow <= 1'b0;
    end else begin
      state <= state_n;
      Fft_valid <= accept;
      Fft_last <= accept && count == 5'd31;
      Error_tag_overflow <= push && full;
      Error_tag_underflow <= pop && empty;
      if (do_push) begin
        grant <= pick;
`ifndef FFT_SCHED_FIXED_PRIORITY_EN
        rr_ptr <= pick;
`endif
        count <= '0;
        Chan_ready <= NUM_CHANNELS'(1) << pick;
        tag_mem[wr_ptr] <= pick;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (accept) begin
        Fft_i <= sel_i;
        Fft_q <= sel_q;
        Fft_index <= count;
        count <= count + 5'd1;
        if (count == 5'd31) begin
          Chan_ready <= '0;
          gap_cnt <= 8'(MIN_FRAME_GAP);
        end
      end
      if (state == S_GAP) gap_cnt <= gap_cnt - 8'd1;
      rd_ptr <= rd_ptr_n;
      occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // Bypass the tag being written when it lands at the new head (push into an empty FIFO).
      Out_channel <= (do_push && wr_ptr == rd_ptr_n) ? pick : tag_mem[rd_ptr_n];
    end
  end
endmodule

// File: tb/tb_fft_32_frame_scheduler.sv
// tb_fft_32_frame_scheduler: scoreboard bench for fft_32_frame_scheduler (grant order, sample stream, gaps, tag FIFO, reset).
module tb_fft_32_frame_scheduler;
  localparam int N = 4, DW = 16;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [N-1:0] Chan_valid = '0, Chan_ready;
  logic [N*DW-1:0] Chan_i, Chan_q;
  logic Fft_valid, Fft_last, Error_tag_overflow, Error_tag_underflow;
  logic Fft_out_valid = 1'b0, Fft_out_last = 1'b0;
  logic [DW-1:0] Fft_i, Fft_q;
  logic [4:0] Fft_index;
  logic [1:0] Out_channel;
  typedef struct packed {logic [DW-1:0] i; logic [DW-1:0] q; logic [4:0] idx; logic last;} smp_t;
  smp_t exp_q[$];
  int grant_q[$];
  int total = 0, bad = 0, ovf_seen = 0;
  int acc_cnt [N] = '{default: 0};
  logic [4:0] fidx [N] = '{default: '0};
  logic [N-1:0] prev_ready = '0;
  int gseq [5];
  always #5 Clk = ~Clk;
  fft_32_frame_scheduler dut (
    .Clk(Clk), .Rst(Rst), .Chan_valid(Chan_valid), .Chan_i(Chan_i), .Chan_q(Chan_q),
    .Chan_ready(Chan_ready), .Fft_valid(Fft_valid), .Fft_i(Fft_i), .Fft_q(Fft_q),
    .Fft_index(Fft_index), .Fft_last(Fft_last), .Fft_out_valid(Fft_out_valid),
    .Fft_out_last(Fft_out_last), .Out_channel(Out_channel),
    .Error_tag_overflow(Error_tag_overflow), .Error_tag_underflow(Error_tag_underflow)
  );
  function automatic logic [DW-1:0] samp_i(int c, int k);
    return DW'(c * 4096 + (k & 4095));
  endfunction
  function automatic logic [DW-1:0] samp_q(int c, int k);
    return ~samp_i(c, k) ^ 16'h5a5a;
  endfunction
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial forever begin
    for (int c = 0; c < N; c++) begin
      Chan_i[c*DW +: DW] = samp_i(c, acc_cnt[c]);
      Chan_q[c*DW +: DW] = samp_q(c, acc_cnt[c]);
    end
    @(posedge Clk);
    #1;
  end
  initial forever begin
    @(negedge Clk);
    if (Rst) begin
      for (int c = 0; c < N; c++) fidx[c] = '0;
    end else begin
      for (int c = 0; c < N; c++)
        if (Chan_valid[c] && Chan_ready[c]) begin
          exp_q.push_back('{i: samp_i(c, acc_cnt[c]), q: samp_q(c, acc_cnt[c]), idx: fidx[c], last: fidx[c] == 5'd31});
          acc_cnt[c]++;
          fidx[c] = fidx[c] + 5'd1;
        end
    end
  end
  initial forever begin
    @(negedge Clk);
    if (Error_tag_overflow) ovf_seen++;
    if (Chan_ready != '0 && prev_ready == '0) begin
      if (grant_q.size() == 0) chk("grant_unexpected", int'(Chan_ready), 0);
      else chk("grant_ready", int'(Chan_ready), 1 << grant_q.pop_front());
    end
    prev_ready = Chan_ready;
    if (Fft_valid) begin
      if (exp_q.size() == 0) chk("fft_unexpected_sample", 1, 0);
      else begin
        smp_t e;
        e = exp_q.pop_front();
        chk("fft_i", int'(Fft_i), int'(e.i));
        chk("fft_q", int'(Fft_q), int'(e.q));
        chk("fft_index", int'(Fft_index), int'(e.idx));
        chk("fft_last", int'(Fft_last), int'(e.last));
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic wait_last(input string name, output int ncyc, output int nval);
    ncyc = 0;
    nval = 0;
    do begin
      @(negedge Clk);
      ncyc++;
      nval += int'(Fft_valid);
    end while (!Fft_last && ncyc < 1000);
    if (!Fft_last) chk({name, "_timeout"}, 0, 1);
  endtask
  task automatic pop_once(output logic udf);
    Fft_out_valid = 1'b1;
    Fft_out_last = 1'b1;
    @(posedge Clk);
    #1;
    Fft_out_valid = 1'b0;
    Fft_out_last = 1'b0;
    @(negedge Clk);
    udf = Error_tag_underflow;
  endtask
  task automatic reset_dut();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    Chan_valid = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask
  task automatic count_accepts(input int ch, input int target, output int n);
    int guard;
    n = 0;
    guard = 0;
    while (n < target && guard < 300) begin
      @(negedge Clk);
      guard++;
      if (Chan_valid[ch] && Chan_ready[ch]) n++;
    end
  endtask
  initial begin
    int nc, nv, g, vcnt, rcnt, n;
    logic u;
    logic [6:0] pat;
`ifdef FFT_SCHED_FIXED_PRIORITY_EN
    gseq = '{0, 0, 0, 0, 0};
`else
    gseq = '{0, 1, 2, 3, 0};
`endif
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_fft_valid", int'(Fft_valid), 0);
    chk("rst_chan_ready", int'(Chan_ready), 0);
    chk("rst_fft_index", int'(Fft_index), 0);
    chk("rst_fft_last", int'(Fft_last), 0);
    chk("rst_out_channel", int'(Out_channel), 0);
    chk("rst_err_ovf", int'(Error_tag_overflow), 0);
    chk("rst_err_udf", int'(Error_tag_underflow), 0);
    grant_q.push_back(0);
    grant_q.push_back(0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    Chan_valid = 4'b0001;
    @(negedge Clk);
    chk("a_ready_idle", int'(Chan_ready), 0);
    @(negedge Clk);
    chk("a_ready_after_grant", int'(Chan_ready), 1);
    wait_last("a_frame1", nc, nv);
    g = 0;
    do begin
      @(negedge Clk);
      g++;
    end while (!Fft_valid && g < 200);
    chk("a_gap_cycles", g, 34);
    wait_last("a_frame2", nc, nv);
    chk("a_frame2_valid_run", nv, 31);
    chk("a_frame2_len", nc, 31);
    @(posedge Clk);
    #1;
    Chan_valid = '0;
    for (int k = 0; k < 5; k++) grant_q.push_back(gseq[k]);
    reset_dut();
    Chan_valid = 4'b1111;
    for (int k = 0; k < 4; k++) wait_last("b_frame", nc, nv);
    vcnt = 0;
    rcnt = 0;
    repeat (60) begin
      @(negedge Clk);
      vcnt += int'(Fft_valid);
      rcnt += int'(Chan_ready != '0);
    end
    chk("b_full_no_valid", vcnt, 0);
    chk("b_full_no_ready", rcnt, 0);
    chk("b_head0", int'(Out_channel), gseq[0]);
    pop_once(u);
    chk("b_head1", int'(Out_channel), gseq[1]);
    chk("b_pop_no_udf", int'(u), 0);
    wait_last("b_frame5", nc, nv);
    @(posedge Clk);
    #1;
    Chan_valid = '0;
    for (int k = 2; k < 5; k++) begin
      pop_once(u);
      chk("b_head", int'(Out_channel), gseq[k]);
    end
    pop_once(u);
    chk("b_last_pop_no_udf", int'(u), 0);
    pop_once(u);
    chk("b_udf_pulse", int'(u), 1);
    @(negedge Clk);
    chk("b_udf_one_cycle", int'(Error_tag_underflow), 0);
    grant_q.push_back(1);
    reset_dut();
    Chan_valid = 4'b0110;
    count_accepts(1, 10, n);
    chk("c_reach_sample10", n, 10);
    @(posedge Clk);
    #1;
    Chan_valid[1] = 1'b0;
    rcnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      pat[k] = Fft_valid;
      rcnt += int'(Chan_ready == 4'b0010);
      if (k == 4) begin
        @(posedge Clk);
        #1;
        Chan_valid[1] = 1'b1;
      end
    end
    chk("c_bubble_pattern", int'(pat), 7'b1000001);
    chk("c_ready_held", rcnt, 7);
    wait_last("c_frame", nc, nv);
    @(posedge Clk);
    #1;
    Chan_valid = '0;
    grant_q.push_back(0);
    grant_q.push_back(0);
    grant_q.push_back(3);
    reset_dut();
    Chan_valid = 4'b1001;
    count_accepts(0, 17, n);
    chk("d_reach_sample17", n, 17);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    chk("d_index_before_reset", int'(Fft_index), 16);
    @(negedge Clk);
    chk("d_reset_fft_valid", int'(Fft_valid), 0);
    chk("d_reset_chan_ready", int'(Chan_ready), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    g = 0;
    do begin
      @(negedge Clk);
      g++;
    end while (!Fft_valid && g < 200);
    chk("d_restart_index", int'(Fft_index), 0);
    wait_last("d_frame", nc, nv);
    @(posedge Clk);
    #1;
    Chan_valid = 4'b1000;
    wait_last("d_frame_ch3", nc, nv);
    @(posedge Clk);
    #1;
    Chan_valid = '0;
    repeat (5) @(negedge Clk);
    chk("end_samples_drained", exp_q.size(), 0);
    chk("end_grants_consumed", grant_q.size(), 0);
    chk("end_no_overflow", ovf_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
